mem_read_arbiter: RTL and testbench

Two-port arbiter that shares the single variable-latency read-only memory port (rreq/raddr in, rdata/data_valid out) between the instruction-fetch requester (port 0) and the data-load requester (port 1). It accepts one read at a time, keeps the memory request and address stable until the memory returns data, and routes the returned word to the owning port. It sits between the core's fetch/LSU units and the memory model.

---
 rtl/mem_read_arbiter_if.sv | 36 +++
 rtl/mem_read_arbiter.sv | 114 +++++++++++
 tb/tb_mem_read_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_if.sv
// rtl/mem_read_arbiter_if.sv - requester and memory-port signals of the two-port read arbiter
// master: arbiter view; slave: requester/memory view.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              resp_valid0;
    logic              resp_valid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;
    logic              mem_rreq;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              busy;

    modport master (
        input  req0, req1, addr0, addr1, mem_rdata, mem_data_valid,
        output gnt0, gnt1, resp_valid0, resp_valid1, rdata0, rdata1,
               err0, err1, mem_rreq, mem_raddr, busy
    );

    modport slave (
        output req0, req1, addr0, addr1, mem_rdata, mem_data_valid,
        input  gnt0, gnt1, resp_valid0, resp_valid1, rdata0, rdata1,
               err0, err1, mem_rreq, mem_raddr, busy
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one variable-latency read port between two requesters
// Optional MEM_ARB_TIMEOUT_EN: BUSY timeout giving an error response, then DRAIN of the late read.
module mem_read_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_read_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
`ifdef MEM_ARB_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t            state_q;
    logic              prio_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic              err_q;
    logic [15:0]       cnt_q;
`endif

    logic idle_ok;
    logic take0;
    logic take1;

    // A lone requester wins outright; prio only breaks ties.
    assign idle_ok = (state_q == S_IDLE) && !reset;
    assign take0   = idle_ok && bus.req0 && (!bus.req1 || !prio_q);
    assign take1   = idle_ok && bus.req1 && (!bus.req0 || prio_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (take0 || take1) begin
                        owner_q <= take1;
                        addr_q  <= take1 ? bus.addr1 : bus.addr0;
                        prio_q  <= !take1;
                        state_q <= S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (bus.mem_data_valid) begin
                        data_q  <= bus.mem_rdata;
                        state_q <= S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                        err_q   <= 1'b0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= cnt_q + 16'd1;
`endif
                    end
                end
                S_RESP: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    // The timed-out read is still in flight; wait for it before reusing the port.
                    state_q <= err_q ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.mem_data_valid) begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt0        = take0;
    assign bus.gnt1        = take1;
    assign bus.resp_valid0 = (state_q == S_RESP) && !owner_q;
    assign bus.resp_valid1 = (state_q == S_RESP) && owner_q;
    assign bus.rdata0      = bus.resp_valid0 ? data_q : '0;
    assign bus.rdata1      = bus.resp_valid1 ? data_q : '0;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err0        = bus.resp_valid0 && err_q;
    assign bus.err1        = bus.resp_valid1 && err_q;
`else
    assign bus.err0        = 1'b0;
    assign bus.err1        = 1'b0;
`endif
    assign bus.mem_rreq    = (state_q == S_BUSY);
    assign bus.mem_raddr   = addr_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - directed self-checking bench for mem_read_arbiter
// Timeout scenario follows MEM_ARB_TIMEOUT_EN when the macro is defined.
module tb_mem_read_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_read_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Tasks start and end just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, ".gnt0"}, 32'(bus.gnt0), 32'd0);
        check({tag, ".gnt1"}, 32'(bus.gnt1), 32'd0);
        check({tag, ".rv0"}, 32'(bus.resp_valid0), 32'd0);
        check({tag, ".rv1"}, 32'(bus.resp_valid1), 32'd0);
        check({tag, ".rdata0"}, bus.rdata0, 32'd0);
        check({tag, ".rdata1"}, bus.rdata1, 32'd0);
        check({tag, ".err0"}, 32'(bus.err0), 32'd0);
        check({tag, ".err1"}, 32'(bus.err1), 32'd0);
        check({tag, ".rreq"}, 32'(bus.mem_rreq), 32'd0);
        check({tag, ".raddr"}, bus.mem_raddr, 32'd0);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic grant_chk(input int port);
        @(negedge clk);
        check("grant.gnt0", 32'(bus.gnt0), 32'(port == 0));
        check("grant.gnt1", 32'(bus.gnt1), 32'(port == 1));
        check("grant.rreq", 32'(bus.mem_rreq), 32'd0);
        check("grant.busy", 32'(bus.busy), 32'd0);
        tick();
    endtask

    // d BUSY cycles before mem_data_valid, then the response cycle.
    task automatic complete(input int port, input logic [31:0] addr, input int d, input logic [31:0] data);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            check("busy.rreq", 32'(bus.mem_rreq), 32'd1);
            check("busy.raddr", bus.mem_raddr, addr);
            check("busy.rv", 32'({bus.resp_valid0, bus.resp_valid1}), 32'd0);
            tick();
        end
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = data;
        @(negedge clk);
        check("dv.rreq", 32'(bus.mem_rreq), 32'd1);
        check("dv.raddr", bus.mem_raddr, addr);
        tick();
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = 32'h0BAD_0BAD;
        @(negedge clk);
        check("resp.rv0", 32'(bus.resp_valid0), 32'(port == 0));
        check("resp.rv1", 32'(bus.resp_valid1), 32'(port == 1));
        check("resp.rdata0", bus.rdata0, (port == 0) ? data : 32'd0);
        check("resp.rdata1", bus.rdata1, (port == 1) ? data : 32'd0);
        check("resp.err", 32'({bus.err0, bus.err1}), 32'd0);
        check("resp.rreq", 32'(bus.mem_rreq), 32'd0);
        check("resp.busy", 32'(bus.busy), 32'd1);
        tick();
    endtask

    task automatic xact(input int port, input logic [31:0] addr, input int d, input logic [31:0] data);
        grant_chk(port);
        complete(port, addr, d, data);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.mem_rdata = '0;
        bus.mem_data_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_quiet("reset");
        tick();
        reset = 1'b0;

        // Single read, 5 BUSY cycles before data; req dropped and address changed after grant.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h4;
        grant_chk(0);
        bus.req0 = 1'b0;
        bus.addr0 = 32'h99;
        complete(0, 32'h4, 5, 32'hDEAD_BEEF);
        @(negedge clk);
        check("single.idle_busy", 32'(bus.busy), 32'd0);
        check("single.idle_rv0", 32'(bus.resp_valid0), 32'd0);
        check("single.idle_rdata0", bus.rdata0, 32'd0);
        tick();

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr0 = 32'h100;
        bus.addr1 = 32'h200;
        xact(0, 32'h100, 2, 32'hD000_0100);
        xact(1, 32'h200, 3, 32'hD000_0200);
        xact(0, 32'h100, 1, 32'hD000_0100);
        xact(1, 32'h200, 4, 32'hD000_0200);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Fastest memory: resp at T+3, rreq low two cycles before the next read.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h10;
        grant_chk(0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.addr1 = 32'h20;
        complete(0, 32'h10, 1, 32'h1111_0010);
        xact(1, 32'h20, 1, 32'h2222_0020);
        bus.req1 = 1'b0;

        // Withdrawn req1 during BUSY, then a stray mem_data_valid while IDLE.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h40;
        grant_chk(0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.addr1 = 32'h80;
        @(negedge clk);
        check("withdraw.gnt1_busy", 32'(bus.gnt1), 32'd0);
        tick();
        bus.req1 = 1'b0;
        complete(0, 32'h40, 2, 32'hCAFE_0040);
        @(negedge clk);
        check("withdraw.gnt1_idle", 32'(bus.gnt1), 32'd0);
        check("withdraw.busy", 32'(bus.busy), 32'd0);
        tick();
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata = 32'h1234;
        @(negedge clk);
        check("stray.busy", 32'(bus.busy), 32'd0);
        tick();
        bus.mem_data_valid = 1'b0;
        @(negedge clk);
        check("stray.rv", 32'({bus.resp_valid0, bus.resp_valid1}), 32'd0);
        check("stray.rdata0", bus.rdata0, 32'd0);
        check("stray.busy2", 32'(bus.busy), 32'd0);
        tick();

        // Reset at T+2: read lost, then a lone req1 is granted.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h50;
        grant_chk(0);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("rstbusy.rreq_t1", 32'(bus.mem_rreq), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rstbusy.busy_t2", 32'(bus.busy), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("rstbusy.after");
        tick();
        bus.req1 = 1'b1;
        bus.addr1 = 32'h60;
        xact(1, 32'h60, 1, 32'h6666_0060);
        bus.req1 = 1'b0;

        // Reset after a port-0 grant restores prio 0: tie goes to port 0.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h70;
        grant_chk(0);
        bus.req0 = 1'b0;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.addr1 = 32'h74;
        xact(0, 32'h70, 1, 32'h7777_0070);
        xact(1, 32'h74, 1, 32'h7777_0074);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Memory stalled 20 cycles.
        bus.req0 = 1'b1;
        bus.addr0 = 32'h300;
        grant_chk(0);
        bus.req0 = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("to.busy_rreq", 32'(bus.mem_rreq), 32'd1);
            tick();
        end
        @(negedge clk);
        check("to.rv0", 32'(bus.resp_valid0), 32'd1);
        check("to.err0", 32'(bus.err0), 32'd1);
        check("to.rdata0", bus.rdata0, 32'd0);
        check("to.rv1", 32'(bus.resp_valid1), 32'd0);
        tick();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("drain.busy", 32'(bus.busy), 32'd1);
            check("drain.rreq", 32'(bus.mem_rreq), 32'd0);
            check("drain.rv0", 32'(bus.resp_valid0), 32'd0);
            tick();
        end
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata = 32'h5555_0300;
        @(negedge clk);
        check("drain.busy_dv", 32'(bus.busy), 32'd1);
        tick();
        bus.mem_data_valid = 1'b0;
        @(negedge clk);
        check("drain.idle", 32'(bus.busy), 32'd0);
        check("drain.no_resp", 32'({bus.resp_valid0, bus.resp_valid1}), 32'd0);
        tick();
`else
        complete(0, 32'h300, 20, 32'h5555_0300);
        @(negedge clk);
        check("stall.idle", 32'(bus.busy), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
